mastermind_ctrl: RTL

- Round sequencer for the Mastermind game.
- Stores a 4-digit secret and a 4-digit guess, one digit per `confirma` pulse.
- Scores the guess serially by counting exact-position hits, and tracks attempts up to a win or loss.
- Drives the position select `{modo,s1,s0}` to the board's 3-to-8 position decoder:
  - `modo=0`: secret slots.
  - `modo=1`: guess slots.
  - `{s1,s0}`: position index.

---
 rtl/mastermind_pkg.sv | 17 +
 rtl/mastermind_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mastermind_pkg.sv
// Shared constants for the Mastermind round sequencer:
// state codes, position count and bank-select values.
package mastermind_pkg;

    localparam logic [2:0] SENHA     = 3'd0;
    localparam logic [2:0] PALPITE   = 3'd1;
    localparam logic [2:0] COMPARA   = 3'd2;
    localparam logic [2:0] RESULTADO = 3'd3;
    localparam logic [2:0] VITORIA   = 3'd4;
    localparam logic [2:0] DERROTA   = 3'd5;

    localparam int NUM_POS = 4;

    localparam logic MODO_SENHA   = 1'b0;
    localparam logic MODO_PALPITE = 1'b1;

endpackage

// File: rtl/mastermind_ctrl.sv
// Mastermind round sequencer: stores secret and guess, scores
// exact hits serially over four cycles and tracks attempts.
module mastermind_ctrl
    import mastermind_pkg::*;
#(
    parameter int DIGIT_W  = 3,
    parameter int MAX_TENT = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIGIT_W-1:0] digito,
    input  logic               confirma,
    output logic               modo,
    output logic               s1,
    output logic               s0,
    output logic [2:0]         acertos,
    output logic [3:0]         tentativas,
    output logic               ocupado,
    output logic               resultado_valido,
    output logic               venceu,
    output logic               perdeu
);

    logic [2:0]         r_state;
    logic [1:0]         r_pos;
    logic [DIGIT_W-1:0] r_secret [NUM_POS];
    logic [DIGIT_W-1:0] r_guess  [NUM_POS];
    logic [2:0]         r_acc;
    logic [2:0]         r_acertos;
    logic [3:0]         r_tent;

    logic       w_match;
    logic [2:0] w_total;
    logic       w_legal;
    logic       w_clear;
    logic [3:0] w_max;

    assign w_max   = 4'(MAX_TENT);
    assign w_match = (r_secret[r_pos] == r_guess[r_pos]);
    assign w_total = r_acc + 3'(w_match);

    assign w_legal = (r_state == SENHA)     ||
                     (r_state == PALPITE)   ||
                     (r_state == COMPARA)   ||
                     (r_state == RESULTADO) ||
                     (r_state == VITORIA)   ||
                     (r_state == DERROTA);

    // End of game on confirma, or a corrupted state, restarts the round.
    assign w_clear = !w_legal ||
                     (confirma &&
                      ((r_state == VITORIA) ||
                       (r_state == DERROTA)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SENHA;
            r_pos     <= 2'd0;
            r_acc     <= 3'd0;
            r_acertos <= 3'd0;
            r_tent    <= 4'd0;
            for (int i = 0; i < NUM_POS; i++) begin
                r_secret[i] <= '0;
                r_guess[i]  <= '0;
            end
        end else if (w_clear) begin
            r_state   <= SENHA;
            r_pos     <= 2'd0;
            r_acc     <= 3'd0;
            r_acertos <= 3'd0;
            r_tent    <= 4'd0;
            for (int i = 0; i < NUM_POS; i++) begin
                r_secret[i] <= '0;
                r_guess[i]  <= '0;
            end
        end else begin
            unique case (r_state)
                SENHA: begin
                    if (confirma) begin
                        r_secret[r_pos] <= digito;
                        r_pos           <= r_pos + 2'd1;
                        if (r_pos == 2'd3) begin
                            r_state <= PALPITE;
                        end
                    end
                end
                PALPITE: begin
                    if (confirma) begin
                        r_guess[r_pos] <= digito;
                        r_pos          <= r_pos + 2'd1;
                        if (r_pos == 2'd3) begin
                            r_state <= COMPARA;
                            r_acc   <= 3'd0;
                            r_tent  <= r_tent + 4'd1;
                        end
                    end
                end
                COMPARA: begin
                    r_pos <= r_pos + 2'd1;
                    if (r_pos == 2'd3) begin
                        r_acertos <= w_total;
                        if (w_total == 3'd4) begin
                            r_state <= VITORIA;
                        end else if (r_tent == w_max) begin
                            r_state <= DERROTA;
                        end else begin
                            r_state <= RESULTADO;
                        end
                    end else begin
                        r_acc <= w_total;
                    end
                end
                RESULTADO: begin
                    if (confirma) begin
                        r_state <= PALPITE;
                        r_pos   <= 2'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign modo = (r_state == SENHA) ? MODO_SENHA : MODO_PALPITE;
    assign s1   = r_pos[1];
    assign s0   = r_pos[0];

    assign acertos    = r_acertos;
    assign tentativas = r_tent;

    assign ocupado          = (r_state == COMPARA);
    assign venceu           = (r_state == VITORIA);
    assign perdeu           = (r_state == DERROTA);
    assign resultado_valido = (r_state == RESULTADO) ||
                              (r_state == VITORIA)   ||
                              (r_state == DERROTA);

endmodule
